// File: rtl/eth10g_link_sequencer.sv
// eth10g_link_sequencer
//
// Per-lane bring-up controller for the 10G Ethernet SFP test path. Each lane
// is held in GT/PCS reset for a fixed time, then waits for receive block lock,
// qualifies that lock as stable, and finally reports the link as up. A lane
// that times out waiting for lock, or that loses lock once up, goes back to
// reset and bumps a saturating retry counter. Two board LEDs show "all lanes
// up" and a free-running heartbeat.
//
// Ports:
//   sysclk_100m    in   1            system clock, the only clock
//   sys_reset_n    in   1            asynchronous active-low reset
//   force_reset    in   SFP_COUNT    per-lane synchronous restart request
//   gt_block_lock  in   SFP_COUNT    per-lane block lock (asynchronous)
//   gt_reset       out  SFP_COUNT    per-lane GT/PCS reset, active-high
//   link_up        out  SFP_COUNT    per-lane qualified link status
//   retry_cnt      out  8*SFP_COUNT  per-lane saturating retry count, lane i at [8i+7:8i]
//   sleds          out  2            [0] all lanes up (registered), [1] heartbeat

module eth10g_link_sequencer #(
    parameter int SFP_COUNT     = 1,
    parameter int RESET_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT  = 10_000_000,
    parameter int STABLE_CYCLES = 100_000,
    parameter int BLINK_CYCLES  = 50_000_000
) (
    input  logic                   sysclk_100m,
    input  logic                   sys_reset_n,
    input  logic [SFP_COUNT-1:0]   force_reset,
    input  logic [SFP_COUNT-1:0]   gt_block_lock,
    output logic [SFP_COUNT-1:0]   gt_reset,
    output logic [SFP_COUNT-1:0]   link_up,
    output logic [8*SFP_COUNT-1:0] retry_cnt,
    output logic [1:0]             sleds
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_UP
    } lane_state_t;

    // The per-lane counter is shared by all states, so it must cover the
    // longest interval; it only ever reaches (interval - 1).
    localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BW      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

    logic [SFP_COUNT-1:0] lock_meta;
    logic [SFP_COUNT-1:0] lock_s;

    lane_state_t state_q [SFP_COUNT];
    lane_state_t state_d [SFP_COUNT];
    logic [CW-1:0] cnt_q [SFP_COUNT];
    logic [CW-1:0] cnt_d [SFP_COUNT];
    logic [7:0]    retry_q [SFP_COUNT];
    logic [7:0]    retry_d [SFP_COUNT];

    logic          all_up_q;
    logic          blink_q;
    logic [BW-1:0] blink_cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchronizer for the asynchronous block-lock inputs.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            lock_meta <= '0;
            lock_s    <= '0;
        end else begin
            lock_meta <= gt_block_lock;
            lock_s    <= lock_meta;
        end
    end

    // Lane state, shared counter and retry count registers.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                state_q[i] <= ST_RST;
                cnt_q[i]   <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                retry_q[i] <= retry_d[i];
            end
        end
    end

    // Next-state logic. force_reset overrides everything and pins the counter
    // at zero, so the reset interval restarts from the cycle it is released.
    // Losing lock in STABLE is not a retry: it just falls back to WAIT_LOCK
    // with a fresh timeout.
    always_comb begin
        for (int i = 0; i < SFP_COUNT; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            retry_d[i] = retry_q[i];

            if (force_reset[i]) begin
                state_d[i] = ST_RST;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_RST: begin
                        if (cnt_q[i] == RESET_LAST) begin
                            state_d[i] = ST_WAIT_LOCK;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s[i]) begin
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == LOCK_LAST) begin
                            state_d[i] = ST_RST;
                            cnt_d[i]   = '0;
                            retry_d[i] = sat_inc(retry_q[i]);
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!lock_s[i]) begin
                            state_d[i] = ST_WAIT_LOCK;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == STABLE_LAST) begin
                            state_d[i] = ST_UP;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    ST_UP: begin
                        if (!lock_s[i]) begin
                            state_d[i] = ST_RST;
                            cnt_d[i]   = '0;
                            retry_d[i] = sat_inc(retry_q[i]);
                        end
                    end
                    default: begin
                        state_d[i] = ST_RST;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Lane outputs are pure decodes of the state register.
    always_comb begin
        gt_reset  = '0;
        link_up   = '0;
        retry_cnt = '0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            gt_reset[i]         = (state_q[i] == ST_RST);
            link_up[i]          = (state_q[i] == ST_UP);
            retry_cnt[8*i +: 8] = retry_q[i];
        end
    end

    // Status LEDs: registered all-up indicator and free-running heartbeat.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            all_up_q    <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            all_up_q <= &link_up;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    assign sleds = {blink_q, all_up_q};

endmodule

// File: tb/tb_eth10g_link_sequencer.sv
// Testbench for eth10g_link_sequencer with two lanes and short intervals
// (reset 4, lock timeout 20, stable 8, blink 10). Edge numbers in comments
// count rising clock edges since sys_reset_n was last released.

module tb_eth10g_link_sequencer;

    logic        sysclk_100m;
    logic        sys_reset_n;
    logic [1:0]  force_reset;
    logic [1:0]  gt_block_lock;
    logic [1:0]  gt_reset;
    logic [1:0]  link_up;
    logic [15:0] retry_cnt;
    logic [1:0]  sleds;

    int n_vec;
    int n_err;
    int edge_no;

    typedef struct {
        string      name;
        int         adv;
        logic [1:0] frc;
        logic [1:0] lock;
        logic [1:0] gt;
        logic [1:0] lu;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [1:0] sl;
    } vec_t;

    vec_t vecs [19];

    eth10g_link_sequencer #(
        .SFP_COUNT    (2),
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .BLINK_CYCLES (10)
    ) dut (
        .sysclk_100m  (sysclk_100m),
        .sys_reset_n  (sys_reset_n),
        .force_reset  (force_reset),
        .gt_block_lock(gt_block_lock),
        .gt_reset     (gt_reset),
        .link_up      (link_up),
        .retry_cnt    (retry_cnt),
        .sleds        (sleds)
    );

    initial sysclk_100m = 1'b0;
    always #5 sysclk_100m = ~sysclk_100m;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk_100m);
            edge_no++;
        end
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] frc, input logic [1:0] lock, input int adv);
        force_reset   = frc;
        gt_block_lock = lock;
        step(adv);
    endtask

    task automatic check_field(input string name, input string field,
                               input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s.%s got %0h expected %0h (edge %0d)", name, field, got, exp, edge_no);
        end
    endtask

    task automatic check_output(input string name, input logic [1:0] e_gt, input logic [1:0] e_lu,
                                input logic [7:0] e_r0, input logic [7:0] e_r1, input logic [1:0] e_sl);
        check_field(name, "gt_reset", {6'd0, gt_reset}, {6'd0, e_gt});
        check_field(name, "link_up", {6'd0, link_up}, {6'd0, e_lu});
        check_field(name, "retry0", retry_cnt[7:0], e_r0);
        check_field(name, "retry1", retry_cnt[15:8], e_r1);
        check_field(name, "sleds", {6'd0, sleds}, {6'd0, e_sl});
    endtask

    // Heartbeat reference: toggles on every 10th edge after release.
    task automatic check_lane(input string name, input logic [1:0] e_gt, input logic [1:0] e_lu,
                              input logic [7:0] e_r0, input logic [7:0] e_r1, input logic e_all);
        logic blink;
        blink = ((edge_no / 10) % 2) == 1;
        check_output(name, e_gt, e_lu, e_r0, e_r1, {blink, e_all});
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        edge_no       = 0;
        sys_reset_n   = 1'b0;
        force_reset   = 2'b00;
        gt_block_lock = 2'b00;

        // Bring-up with lock present, then force_reset on lane 1 and a held
        // force_reset on lane 0. Lock stays high on both lanes throughout.
        vecs[0]  = '{"s1_rst_hold",    3, 2'b00, 2'b11, 2'b11, 2'b00, 8'd0, 8'd0, 2'b00}; // e3
        vecs[1]  = '{"s1_gt_fall",     1, 2'b00, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00}; // e4
        vecs[2]  = '{"s1_pre_up",      8, 2'b00, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10}; // e12
        vecs[3]  = '{"s1_link_up",     1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b10}; // e13
        vecs[4]  = '{"s1_all_up",      1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b11}; // e14
        vecs[5]  = '{"blink_fall",     6, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b01}; // e20
        vecs[6]  = '{"s5_force1",      1, 2'b10, 2'b11, 2'b10, 2'b01, 8'd0, 8'd0, 2'b01}; // e21
        vecs[7]  = '{"s5_led_fall",    1, 2'b00, 2'b11, 2'b10, 2'b01, 8'd0, 8'd0, 2'b00}; // e22
        vecs[8]  = '{"s5_rst_count",   2, 2'b00, 2'b11, 2'b10, 2'b01, 8'd0, 8'd0, 2'b00}; // e24
        vecs[9]  = '{"s5_gt_fall",     1, 2'b00, 2'b11, 2'b00, 2'b01, 8'd0, 8'd0, 2'b00}; // e25
        vecs[10] = '{"s5_pre_up",      8, 2'b00, 2'b11, 2'b00, 2'b01, 8'd0, 8'd0, 2'b10}; // e33
        vecs[11] = '{"s5_lane1_up",    1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b10}; // e34
        vecs[12] = '{"s5_led_rise",    1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b11}; // e35
        vecs[13] = '{"hold_force0",    3, 2'b01, 2'b11, 2'b01, 2'b10, 8'd0, 8'd0, 2'b10}; // e38
        vecs[14] = '{"hold_release",   3, 2'b00, 2'b11, 2'b01, 2'b10, 8'd0, 8'd0, 2'b00}; // e41
        vecs[15] = '{"hold_gt_fall",   1, 2'b00, 2'b11, 2'b00, 2'b10, 8'd0, 8'd0, 2'b00}; // e42
        vecs[16] = '{"hold_pre_up",    8, 2'b00, 2'b11, 2'b00, 2'b10, 8'd0, 8'd0, 2'b10}; // e50
        vecs[17] = '{"hold_up",        1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b10}; // e51
        vecs[18] = '{"hold_led",       1, 2'b00, 2'b11, 2'b00, 2'b11, 8'd0, 8'd0, 2'b11}; // e52

        // Reset values before any clock edge.
        #1;
        check_output("reset_noclk", 2'b11, 2'b00, 8'd0, 8'd0, 2'b00);
        step(2);
        check_output("reset_clk", 2'b11, 2'b00, 8'd0, 8'd0, 2'b00);

        gt_block_lock = 2'b11;
        edge_no       = 0;
        sys_reset_n   = 1'b1;

        for (int v = 0; v < 19; v++) begin
            apply_stimulus(vecs[v].frc, vecs[v].lock, vecs[v].adv);
            check_output(vecs[v].name, vecs[v].gt, vecs[v].lu, vecs[v].r0, vecs[v].r1, vecs[v].sl);
        end

        // Lock loss on lane 0 while up: reset and retry 3 edges later.
        apply_stimulus(2'b00, 2'b10, 2);                            // e54
        check_lane("s4_before", 2'b00, 2'b11, 8'd0, 8'd0, 1'b1);
        step(1);                                                    // e55
        check_lane("s4_drop", 2'b01, 2'b10, 8'd1, 8'd0, 1'b1);
        apply_stimulus(2'b00, 2'b11, 3);                            // e58
        check_lane("s4_rst", 2'b01, 2'b10, 8'd1, 8'd0, 1'b0);
        step(1);                                                    // e59
        check_lane("s4_gt_fall", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(8);                                                    // e67
        check_lane("s4_pre_up", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(1);                                                    // e68
        check_lane("s4_up", 2'b00, 2'b11, 8'd1, 8'd0, 1'b0);

        // One-cycle lock glitch in STABLE on lane 0 restarts qualification.
        apply_stimulus(2'b01, 2'b11, 1);                            // e69
        check_lane("s3_force", 2'b01, 2'b10, 8'd1, 8'd0, 1'b1);
        apply_stimulus(2'b00, 2'b11, 4);                            // e73
        check_lane("s3_wait", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(3);                                                    // e76, STABLE cnt 2
        apply_stimulus(2'b00, 2'b10, 1);                            // e77
        apply_stimulus(2'b00, 2'b11, 2);                            // e79
        check_lane("s3_back_wait", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(3);                                                    // e82
        check_lane("s3_no_early_up", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(5);                                                    // e87
        check_lane("s3_pre_up", 2'b00, 2'b10, 8'd1, 8'd0, 1'b0);
        step(1);                                                    // e88
        check_lane("s3_up", 2'b00, 2'b11, 8'd1, 8'd0, 1'b0);

        // Lane 1 loses lock and never regains it: 24-cycle retry period.
        apply_stimulus(2'b00, 2'b01, 2);                            // e90
        check_lane("s2_before", 2'b00, 2'b11, 8'd1, 8'd0, 1'b1);
        step(1);                                                    // e91
        check_lane("s2_drop", 2'b10, 2'b01, 8'd1, 8'd1, 1'b1);
        step(3);                                                    // e94
        check_lane("s2_rst", 2'b10, 2'b01, 8'd1, 8'd1, 1'b0);
        step(1);                                                    // e95
        check_lane("s2_wait", 2'b00, 2'b01, 8'd1, 8'd1, 1'b0);
        step(19);                                                   // e114
        check_lane("s2_wait_end", 2'b00, 2'b01, 8'd1, 8'd1, 1'b0);
        step(1);                                                    // e115
        check_lane("s2_timeout1", 2'b10, 2'b01, 8'd1, 8'd2, 1'b0);
        step(23);                                                   // e138
        check_lane("s2_wait2", 2'b00, 2'b01, 8'd1, 8'd2, 1'b0);
        step(1);                                                    // e139
        check_lane("s2_timeout2", 2'b10, 2'b01, 8'd1, 8'd3, 1'b0);
        step(300 * 24);                                             // e7339
        check_lane("s2_saturate", 2'b10, 2'b01, 8'd1, 8'd255, 1'b0);
        step(6);                                                    // e7345, lane 1 in WAIT_LOCK
        check_lane("s6_in_wait", 2'b00, 2'b01, 8'd1, 8'd255, 1'b0);

        // Asynchronous reset mid-WAIT_LOCK, checked before the next edge.
        #2;
        sys_reset_n = 1'b0;
        #1;
        check_output("s6_async_rst", 2'b11, 2'b00, 8'd0, 8'd0, 2'b00);
        apply_stimulus(2'b00, 2'b11, 2);
        check_output("s6_rst_held", 2'b11, 2'b00, 8'd0, 8'd0, 2'b00);
        edge_no     = 0;
        sys_reset_n = 1'b1;
        step(3);
        check_lane("s6_rel_rst", 2'b11, 2'b00, 8'd0, 8'd0, 1'b0);
        step(1);                                                    // e4
        check_lane("s6_gt_fall", 2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
        step(5);                                                    // e9
        check_lane("s6_blink_lo", 2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
        step(1);                                                    // e10
        check_lane("s6_blink_hi", 2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
        step(3);                                                    // e13
        check_lane("s6_up", 2'b00, 2'b11, 8'd0, 8'd0, 1'b0);
        step(6);                                                    // e19
        check_lane("s6_blink_hold", 2'b00, 2'b11, 8'd0, 8'd0, 1'b1);
        step(1);                                                    // e20
        check_lane("s6_blink_lo2", 2'b00, 2'b11, 8'd0, 8'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
